// File: rtl/fir_mac_pkg.sv
// Shared types and arithmetic helpers for the sequential FIR MAC engine.
// The round/saturate helper works on a 64-bit sign-extended accumulator so one
// function serves every parameter set; callers keep only the low DATA_WIDTH bits.
package fir_mac_pkg;

  // Engine control states
  typedef enum logic {
    IDLE,
    MAC
  } state_e;

  // Widest accumulator the round/saturate helper supports
  localparam int MaxAccW = 64;

  // Rounded result plus clip indication
  typedef struct packed {
    logic [MaxAccW-1:0] value;
    logic               ovf;
  } rs_t;

  // Full-precision accumulator width: one product plus log2(TAPS) growth bits
  function automatic int acc_width(input int data_width, input int coef_width, input int taps);
    return data_width + coef_width + $clog2(taps);
  endfunction

  // Round-half-up, arithmetic shift by frac_bits, then clamp to the signed
  // data_width range when sat_en is set. Without sat_en the caller wraps by
  // truncating to data_width bits and ovf stays 0.
  function automatic rs_t round_sat(input logic signed [MaxAccW-1:0] acc,
                                    input int frac_bits,
                                    input int data_width,
                                    input bit sat_en);
    logic signed [MaxAccW-1:0] half;
    logic signed [MaxAccW-1:0] shifted;
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    rs_t                       r;
    half    = (frac_bits == 0) ? '0 : (64'sd1 <<< (frac_bits - 1));
    shifted = (acc + half) >>> frac_bits;
    hi      = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (data_width - 1));
    r.value = shifted;
    r.ovf   = 1'b0;
    if (sat_en) begin
      if (shifted > hi) begin
        r.value = hi;
        r.ovf   = 1'b1;
      end else if (shifted < lo) begin
        r.value = lo;
        r.ovf   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x COEF_WIDTH coefficient register file.
// Writes land only while the engine reports idle (wr_allow) so a result in
// flight never sees a mix of old and new coefficients. Out-of-range addresses
// are dropped. The read port is asynchronous and driven by the MAC tap index.
module fir_coef_bank #(
  parameter int COEF_WIDTH = 13,
  parameter int TAPS       = 8
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     we,
  input  logic                     wr_allow,
  input  logic [$clog2(TAPS)-1:0]  waddr,
  input  logic [COEF_WIDTH-1:0]    wdata,
  input  logic [$clog2(TAPS)-1:0]  raddr,
  output logic [COEF_WIDTH-1:0]    rdata
);

  logic [COEF_WIDTH-1:0] bank_q [TAPS];
  logic                  wr_en;

  assign wr_en = we && wr_allow && (int'(waddr) < TAPS);

  // Gated coefficient write, cleared by reset
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < TAPS; k++) begin
        bank_q[k] <= '0;
      end
    end else if (wr_en) begin
      bank_q[waddr] <= wdata;
    end
  end

  // Asynchronous read of the tap currently being multiplied
  always_comb begin
    rdata = bank_q[raddr];
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate engine with a single time-shared multiplier.
// One sample is accepted per VIN/RDY handshake; TAPS cycles later one rounded
// result appears on DOUT with a one-cycle VOUT pulse.
// Build option: define MAC_SAT_EN to clamp results to the DATA_WIDTH range and
// report clipping on OVF; otherwise the result wraps and OVF stays 0.
module fir_mac_seq
  import fir_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 13,
  parameter int COEF_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int FRAC_BITS  = 12
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    VIN,
  input  logic [DATA_WIDTH-1:0]   DIN,
  output logic                    RDY,
  input  logic                    COEF_WE,
  input  logic [$clog2(TAPS)-1:0] COEF_ADDR,
  input  logic [COEF_WIDTH-1:0]   COEF_DIN,
  output logic [DATA_WIDTH-1:0]   DOUT,
  output logic                    VOUT,
  output logic                    OVF
);

  localparam int AW   = $clog2(TAPS);
  localparam int PW   = DATA_WIDTH + COEF_WIDTH;
  localparam int AccW = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);

`ifdef MAC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e                        state_q;
  logic [AW-1:0]                 idx_q;
  logic signed [AccW-1:0]        acc_q;
  logic signed [DATA_WIDTH-1:0]  x_q [TAPS];
  logic [DATA_WIDTH-1:0]         dout_q;
  logic                          vout_q;
  logic                          ovf_q;

  logic signed [COEF_WIDTH-1:0]  coef;
  logic signed [PW-1:0]          prod;
  logic signed [AccW-1:0]        sum;
  rs_t                           res;
  logic                          accept;
  logic                          last;
  logic                          unused_res;

  assign RDY    = (state_q == IDLE);
  assign accept = VIN && RDY;
  assign last   = (idx_q == AW'(TAPS - 1));

  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign OVF  = ovf_q;

  fir_coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .TAPS       (TAPS)
  ) u_coef_bank (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .we       (COEF_WE),
    .wr_allow (RDY),
    .waddr    (COEF_ADDR),
    .wdata    (COEF_DIN),
    .raddr    (idx_q),
    .rdata    (coef)
  );

  // Current tap product, running sum including it, and the rounded final value
  always_comb begin
    prod = PW'(x_q[idx_q]) * PW'(coef);
    sum  = acc_q + {{(AccW - PW){prod[PW-1]}}, prod};
    res  = round_sat({{(MaxAccW - AccW){sum[AccW-1]}}, sum}, FRAC_BITS, DATA_WIDTH, SatEn);
  end

  // Only the low DATA_WIDTH bits of the helper result reach DOUT
  assign unused_res = ^res.value[MaxAccW-1:DATA_WIDTH];

  // Control FSM, delay line, accumulator and registered outputs
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      vout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q[0] <= DIN;
            for (int k = 1; k < TAPS; k++) begin
              x_q[k] <= x_q[k-1];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (last) begin
            // Final tap: publish the rounded sum and hand control back
            dout_q  <= res.value[DATA_WIDTH-1:0];
            ovf_q   <= res.ovf && SatEn;
            vout_q  <= 1'b1;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= sum;
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq with default parameters. Expected values
// come from a plain-arithmetic model: coefficient and sample arrays, a dot
// product in 64-bit integers, round-half-up and clamp/wrap on the result.
module tb_fir_mac_seq;

  localparam int DW   = 13;
  localparam int CW   = 13;
  localparam int TAPS = 8;
  localparam int FB   = 12;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          VIN;
  logic [DW-1:0] DIN;
  logic          RDY;
  logic          COEF_WE;
  logic [2:0]    COEF_ADDR;
  logic [CW-1:0] COEF_DIN;
  logic [DW-1:0] DOUT;
  logic          VOUT;
  logic          OVF;

  int errors = 0;
  int checks = 0;
  int h_m [TAPS];
  int x_m [TAPS];

  always #5 CLK = ~CLK;

  fir_mac_seq dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .VIN       (VIN),
    .DIN       (DIN),
    .RDY       (RDY),
    .COEF_WE   (COEF_WE),
    .COEF_ADDR (COEF_ADDR),
    .COEF_DIN  (COEF_DIN),
    .DOUT      (DOUT),
    .VOUT      (VOUT),
    .OVF       (OVF)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v, input int w);
    int s;
    s = 32 - w;
    return (v <<< s) >>> s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      h_m[k] = 0;
      x_m[k] = 0;
    end
  endtask

  task automatic model_push(input int s);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = sx(s, DW);
  endtask

  task automatic model_out(output logic [DW-1:0] d, output logic o);
    longint sum;
    longint r;
    longint hi;
    longint lo;
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += longint'(x_m[k]) * longint'(h_m[k]);
    r  = (sum + (longint'(1) <<< (FB - 1))) >>> FB;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    o  = 1'b0;
`ifdef MAC_SAT_EN
    if (r > hi) begin
      r = hi;
      o = 1'b1;
    end else if (r < lo) begin
      r = lo;
      o = 1'b1;
    end
`else
    if (hi < lo) o = 1'b1;
`endif
    d = r[DW-1:0];
  endtask

  task automatic write_coef(input int a, input int v, input bit idle);
    COEF_WE   = 1'b1;
    COEF_ADDR = a[2:0];
    COEF_DIN  = v[CW-1:0];
    step();
    COEF_WE   = 1'b0;
    if (idle) h_m[a] = sx(v, CW);
  endtask

  task automatic accept(input int s);
    int n;
    n = 0;
    while (!RDY && n < 40) begin
      step();
      n++;
    end
    chk("rdy_before_accept", 32'(RDY), 32'd1);
    VIN = 1'b1;
    DIN = s[DW-1:0];
    step();
    VIN = 1'b0;
    model_push(s);
  endtask

  task automatic result(input string tag, input int lat);
    int            n;
    logic [DW-1:0] ed;
    logic          eo;
    n = 0;
    while (!VOUT && n < 40) begin
      step();
      n++;
    end
    model_out(ed, eo);
    chk({tag, "_vout"}, 32'(VOUT), 32'd1);
    if (lat > 0) chk({tag, "_latency"}, n, lat);
    chk({tag, "_dout"}, 32'(DOUT), 32'(ed));
    chk({tag, "_ovf"}, 32'(OVF), 32'(eo));
  endtask

  initial begin
    int            s;
    int            v;
    int            gap;
    int            pulses;
    int            n;
    int            vcount;
    logic [DW-1:0] ed;
    logic          eo;

    RST_n     = 1'b0;
    VIN       = 1'b0;
    DIN       = '0;
    COEF_WE   = 1'b0;
    COEF_ADDR = '0;
    COEF_DIN  = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    step();
    chk("reset_dout", 32'(DOUT), 32'd0);
    chk("reset_vout", 32'(VOUT), 32'd0);
    chk("reset_ovf", 32'(OVF), 32'd0);
    chk("reset_rdy", 32'(RDY), 32'd1);

    // Near-unity tap: 4095/4096 rounds 1000 back to 1000
    write_coef(0, 4095, 1'b1);
    accept(1000);
    chk("mac_rdy_low", 32'(RDY), 32'd0);
    result("unity", TAPS);
    chk("unity_const", 32'(DOUT), 32'd1000);
    repeat (3) step();
    chk("dout_hold", 32'(DOUT), 32'd1000);
    chk("vout_pulse_only", 32'(VOUT), 32'd0);

    // Half-weight tap exercises round-half-up on both signs
    write_coef(0, 2048, 1'b1);
    accept(3);
    result("round_pos", TAPS);
    chk("round_pos_const", 32'(DOUT), 32'd2);
    accept(-3);
    result("round_neg", TAPS);
    chk("round_neg_const", 32'(DOUT), 32'h1fff);

    // Impulse response after flushing the delay line
    for (int k = 0; k < TAPS; k++) write_coef(k, 256 * (k + 1), 1'b1);
    for (int k = 0; k < TAPS; k++) begin
      accept(0);
      result("flush", TAPS);
    end
    accept(4095);
    result("impulse0", TAPS);
    for (int k = 1; k < TAPS; k++) begin
      accept(0);
      result("impulse", TAPS);
    end

    // Large positive and negative sums: clamp or wrap depending on build
    for (int k = 0; k < TAPS; k++) write_coef(k, 4095, 1'b1);
    for (int k = 0; k < TAPS; k++) begin
      accept(4095);
      result("sat_pos", TAPS);
    end
    for (int k = 0; k < TAPS; k++) begin
      accept(-4096);
      result("sat_neg", TAPS);
    end

    // Random coefficients and samples
    for (int k = 0; k < TAPS; k++) write_coef(k, sx(int'($urandom_range(0, 8191)), CW), 1'b1);
    for (int i = 0; i < 10; i++) begin
      accept(sx(int'($urandom_range(0, 8191)), DW));
      result("random", TAPS);
    end

    // VIN held high: one accept every TAPS+1 cycles
    s      = sx(int'($urandom_range(0, 8191)), DW);
    VIN    = 1'b1;
    DIN    = s[DW-1:0];
    gap    = 0;
    pulses = 0;
    n      = 0;
    while (pulses < 3 && n < 60) begin
      step();
      n++;
      gap++;
      if (VOUT) begin
        model_push(s);
        model_out(ed, eo);
        chk("b2b_period", gap, TAPS + 1);
        chk("b2b_dout", 32'(DOUT), 32'(ed));
        pulses++;
        gap = 0;
      end
    end
    VIN = 1'b0;
    chk("b2b_pulses", pulses, 3);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (VOUT) vcount++;
    end
    chk("b2b_no_extra", vcount, 0);

    // Coefficient write during MAC is dropped
    accept(sx(int'($urandom_range(0, 8191)), DW));
    v = sx(int'($urandom_range(0, 8191)), CW);
    if (v == h_m[0]) v = sx(v + 1, CW);
    write_coef(0, v, 1'b0);
    result("gate_inflight", -1);
    accept(sx(int'($urandom_range(0, 8191)), DW));
    result("gate_next", TAPS);

    // Write and accept in the same idle cycle: new coefficient is used
    s = sx(int'($urandom_range(0, 8191)), DW);
    v = sx(int'($urandom_range(0, 8191)), CW);
    chk("same_cycle_rdy", 32'(RDY), 32'd1);
    COEF_WE   = 1'b1;
    COEF_ADDR = 3'd0;
    COEF_DIN  = v[CW-1:0];
    VIN       = 1'b1;
    DIN       = s[DW-1:0];
    step();
    COEF_WE = 1'b0;
    VIN     = 1'b0;
    h_m[0]  = v;
    model_push(s);
    result("same_cycle", TAPS);

    // Reset in the middle of a computation
    accept(sx(int'($urandom_range(0, 8191)), DW));
    repeat (4) step();
    RST_n = 1'b0;
    #1;
    chk("midreset_dout", 32'(DOUT), 32'd0);
    chk("midreset_vout", 32'(VOUT), 32'd0);
    chk("midreset_ovf", 32'(OVF), 32'd0);
    chk("midreset_rdy", 32'(RDY), 32'd1);
    model_reset();
    step();
    RST_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (VOUT) vcount++;
    end
    chk("midreset_no_vout", vcount, 0);
    write_coef(0, 4095, 1'b1);
    accept(1000);
    result("post_reset", TAPS);
    chk("post_reset_const", 32'(DOUT), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
